key_entry_control: RTL and testbench

- Input front-end between the board pushbuttons/switches and main_control.
- Synchronises and debounces the four raw active-low KEY inputs, and turns presses into single-cycle pulses.
- Sequences a two-step operator entry: amount first, then key. Captures the SW[7:0] value at each step.
- Presents the captured pair to the transaction path with a valid/ack handshake, so main_control never sees bouncing or level-held buttons.

---
 rtl/key_entry_control.sv | 84 ++++++++
 tb/tb_key_entry_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_control.sv
// key_entry_control: debounced pushbutton front-end sequencing an amount/key entry with a valid/ack handshake
// Ports: clock/resetn (sync active-low), key_n raw active-low buttons ([0]=start [1]=load [2]=cancel [3]=unused),
//        sw raw switches, entry_ack consumer accept; press_pulse one-cycle press strobes, amount_out/key_out
//        captured values, entry_valid pair complete, busy not IDLE, state_out FSM state.
module key_entry_control #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [3:0]        key_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              entry_ack,
  output logic [3:0]        press_pulse,
  output logic [DATA_W-1:0] amount_out,
  output logic [DATA_W-1:0] key_out,
  output logic              entry_valid,
  output logic              busy,
  output logic [1:0]        state_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, GET_AMOUNT = 2'd1, GET_KEY = 2'd2, READY = 2'd3} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t nxt, state;
  logic [3:0] s1, s2, db, db_q, db_q2;
  logic [CNT_W-1:0] cnt [4];
  logic [DATA_W-1:0] sw_q;
  logic start, load, cancel;
  assign start  = press_pulse[0];
  assign load   = press_pulse[1];
  assign cancel = press_pulse[2];
  // db_q/db_q2 delay the debounced level so the press strobe lands DEBOUNCE_CYCLES+3 edges after the first low sample
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1 <= '1;
      s2 <= '1;
      db <= '1;
      db_q <= '1;
      db_q2 <= '1;
      sw_q <= '0;
      press_pulse <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      db_q <= db;
      db_q2 <= db_q;
      sw_q <= sw;
      press_pulse <= db_q2 & ~db_q;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          db[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  // priority: cancel > entry_ack > load > start
  always_comb begin
    nxt = (state != IDLE && cancel)     ? IDLE :
          (state == READY && entry_ack) ? IDLE :
          (state == GET_AMOUNT && load) ? GET_KEY :
          (state == GET_KEY && load)    ? READY :
          (state == IDLE && start)      ? GET_AMOUNT : state;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      state_out <= 2'd0;
      busy <= 1'b0;
      entry_valid <= 1'b0;
      amount_out <= '0;
      key_out <= '0;
    end else begin
      state <= nxt;
      state_out <= nxt;
      busy <= nxt != IDLE;
      entry_valid <= nxt == READY;
      if (state == GET_AMOUNT && nxt == GET_KEY) amount_out <= sw_q;
      if (state == GET_KEY && nxt == READY) key_out <= sw_q;
    end
  end
endmodule

// File: tb/tb_key_entry_control.sv
// tb_key_entry_control: scoreboard bench for key_entry_control with a short debounce window
module tb_key_entry_control;
  localparam int DEB = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [7:0] sw = 8'h00;
  logic entry_ack = 1'b0;
  logic [3:0] press_pulse;
  logic [7:0] amount_out, key_out;
  logic entry_valid, busy;
  logic [1:0] state_out;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  typedef struct {logic [3:0] val; int lat;} exp_t;
  exp_t exp_q[$];
  key_entry_control #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .DATA_W(8)) dut (
    .clock(clk), .resetn(resetn), .key_n(key_n), .sw(sw), .entry_ack(entry_ack),
    .press_pulse(press_pulse), .amount_out(amount_out), .key_out(key_out),
    .entry_valid(entry_valid), .busy(busy), .state_out(state_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
  task automatic press(input int b, input bit ack_on_pulse);
    int c0;
    bit seen, extra;
    exp_t e;
    @(negedge clk);
    key_n[b] = 1'b0;
    c0 = cyc + 1;
    e.val = 4'b0001 << b;
    e.lat = DEB + 3;
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (press_pulse !== 4'b0) seen = 1'b1;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL press_timeout bit%0d: got no pulse, expected %b", b, e.val);
    end else begin
      if (ack_on_pulse) entry_ack = 1'b1;
      n_cmp++;
      if (press_pulse !== e.val) begin
        n_bad++;
        $display("FAIL press_value bit%0d: got %b expected %b", b, press_pulse, e.val);
      end
      n_cmp++;
      if (cyc - c0 !== e.lat) begin
        n_bad++;
        $display("FAIL press_latency bit%0d: got %0d expected %0d", b, cyc - c0, e.lat);
      end
      @(negedge clk);
      entry_ack = 1'b0;
      n_cmp++;
      if (press_pulse !== 4'b0) begin
        n_bad++;
        $display("FAIL press_width bit%0d: got %b expected 0000", b, press_pulse);
      end
    end
    extra = 1'b0;
    repeat (DEB + 4) begin
      @(negedge clk);
      if (press_pulse !== 4'b0) extra = 1'b1;
    end
    key_n[b] = 1'b1;
    repeat (DEB + 6) begin
      @(negedge clk);
      if (press_pulse !== 4'b0) extra = 1'b1;
    end
    n_cmp++;
    if (extra) begin
      n_bad++;
      $display("FAIL press_extra bit%0d: got extra pulse while held or on release, expected none", b);
    end
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (press_pulse !== 4'b0) begin n_bad++; $display("FAIL reset_pulse: got %b expected 0000", press_pulse); end
    n_cmp++;
    if (amount_out !== 8'h00) begin n_bad++; $display("FAIL reset_amount: got %h expected 00", amount_out); end
    n_cmp++;
    if (key_out !== 8'h00) begin n_bad++; $display("FAIL reset_key: got %h expected 00", key_out); end
    n_cmp++;
    if (entry_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", entry_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (state_out !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state_out); end
  endtask
  task automatic test_debounce_latency;
    press(0, 1'b0);
    n_cmp++;
    if (state_out !== 2'd1) begin n_bad++; $display("FAIL start_state: got %0d expected 1", state_out); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b expected 1", busy); end
    press(2, 1'b0);
    n_cmp++;
    if (state_out !== 2'd0) begin n_bad++; $display("FAIL cancel_amount_state: got %0d expected 0", state_out); end
  endtask
  task automatic test_glitch;
    bit extra;
    @(negedge clk);
    key_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    key_n[1] = 1'b1;
    extra = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (press_pulse !== 4'b0) extra = 1'b1;
    end
    n_cmp++;
    if (extra) begin n_bad++; $display("FAIL glitch_pulse: got pulse expected none"); end
    n_cmp++;
    if (state_out !== 2'd0) begin n_bad++; $display("FAIL glitch_state: got %0d expected 0", state_out); end
  endtask
  task automatic test_full_entry;
    press(0, 1'b0);
    sw = 8'h2A;
    press(1, 1'b0);
    n_cmp++;
    if (state_out !== 2'd2) begin n_bad++; $display("FAIL entry_state2: got %0d expected 2", state_out); end
    sw = 8'h5C;
    press(1, 1'b0);
    n_cmp++;
    if (amount_out !== 8'h2A) begin n_bad++; $display("FAIL entry_amount: got %h expected 2a", amount_out); end
    n_cmp++;
    if (key_out !== 8'h5C) begin n_bad++; $display("FAIL entry_key: got %h expected 5c", key_out); end
    n_cmp++;
    if (state_out !== 2'd3) begin n_bad++; $display("FAIL entry_state3: got %0d expected 3", state_out); end
    n_cmp++;
    if (entry_valid !== 1'b1) begin n_bad++; $display("FAIL entry_valid: got %b expected 1", entry_valid); end
    @(negedge clk);
    entry_ack = 1'b1;
    @(negedge clk);
    entry_ack = 1'b0;
    n_cmp++;
    if (entry_valid !== 1'b0) begin n_bad++; $display("FAIL ack_valid: got %b expected 0", entry_valid); end
    n_cmp++;
    if (state_out !== 2'd0) begin n_bad++; $display("FAIL ack_state: got %0d expected 0", state_out); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ack_busy: got %b expected 0", busy); end
  endtask
  task automatic test_ignored;
    sw = 8'h99;
    press(1, 1'b0);
    n_cmp++;
    if (state_out !== 2'd0) begin n_bad++; $display("FAIL idle_load_state: got %0d expected 0", state_out); end
    n_cmp++;
    if (amount_out !== 8'h2A) begin n_bad++; $display("FAIL idle_load_amount: got %h expected 2a", amount_out); end
    press(0, 1'b0);
    sw = 8'h11;
    press(1, 1'b0);
    press(0, 1'b0);
    n_cmp++;
    if (state_out !== 2'd2) begin n_bad++; $display("FAIL getkey_start_state: got %0d expected 2", state_out); end
    sw = 8'h5C;
    press(1, 1'b0);
    sw = 8'hFF;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (amount_out !== 8'h11) begin n_bad++; $display("FAIL ready_amount_hold: got %h expected 11", amount_out); end
    n_cmp++;
    if (key_out !== 8'h5C) begin n_bad++; $display("FAIL ready_key_hold: got %h expected 5c", key_out); end
    press(1, 1'b0);
    n_cmp++;
    if (state_out !== 2'd3) begin n_bad++; $display("FAIL ready_load_state: got %0d expected 3", state_out); end
  endtask
  task automatic test_cancel_priority;
    press(2, 1'b1);
    n_cmp++;
    if (state_out !== 2'd0) begin n_bad++; $display("FAIL cancel_state: got %0d expected 0", state_out); end
    n_cmp++;
    if (entry_valid !== 1'b0) begin n_bad++; $display("FAIL cancel_valid: got %b expected 0", entry_valid); end
    n_cmp++;
    if (key_out !== 8'h5C) begin n_bad++; $display("FAIL cancel_key_hold: got %h expected 5c", key_out); end
    n_cmp++;
    if (amount_out !== 8'h11) begin n_bad++; $display("FAIL cancel_amount_hold: got %h expected 11", amount_out); end
  endtask
  task automatic test_mid_reset;
    press(0, 1'b0);
    sw = 8'h77;
    press(1, 1'b0);
    n_cmp++;
    if (state_out !== 2'd2) begin n_bad++; $display("FAIL prereset_state: got %0d expected 2", state_out); end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_cmp++;
    if ({press_pulse, amount_out, key_out, entry_valid, busy, state_out} !== 24'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got pulse=%b amt=%h key=%h v=%b b=%b st=%0d expected all 0",
               press_pulse, amount_out, key_out, entry_valid, busy, state_out);
    end
    sw = 8'h33;
    press(1, 1'b0);
    n_cmp++;
    if (state_out !== 2'd0) begin n_bad++; $display("FAIL postreset_load_state: got %0d expected 0", state_out); end
    n_cmp++;
    if (amount_out !== 8'h00) begin n_bad++; $display("FAIL postreset_load_amount: got %h expected 00", amount_out); end
    press(0, 1'b0);
    n_cmp++;
    if (state_out !== 2'd1) begin n_bad++; $display("FAIL postreset_start_state: got %0d expected 1", state_out); end
  endtask
  initial begin
    test_reset;
    test_debounce_latency;
    test_glitch;
    test_full_entry;
    test_ignored;
    test_cancel_priority;
    test_mid_reset;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
